// File: rtl/pm_tap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pm_tap_pkg
//  Description : Shared definitions for the power-management TAP controller.
//                Holds the 4-bit 1149.1 state encoding and the IR capture
//                pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package pm_tap_pkg;

    // Encodings follow the conventional 1149.1 numbering, so a logic
    // analyser on tap_state reads the same codes as other TAP controllers.
    typedef enum logic [3:0] {
        ST_EXIT2_DR   = 4'h0,
        ST_EXIT1_DR   = 4'h1,
        ST_SHIFT_DR   = 4'h2,
        ST_PAUSE_DR   = 4'h3,
        ST_SELECT_IR  = 4'h4,
        ST_UPDATE_DR  = 4'h5,
        ST_CAPTURE_DR = 4'h6,
        ST_SELECT_DR  = 4'h7,
        ST_EXIT2_IR   = 4'h8,
        ST_EXIT1_IR   = 4'h9,
        ST_SHIFT_IR   = 4'hA,
        ST_PAUSE_IR   = 4'hB,
        ST_RTI        = 4'hC,
        ST_UPDATE_IR  = 4'hD,
        ST_CAPTURE_IR = 4'hE,
        ST_TLR        = 4'hF
    } tap_state_e;

    // Low two bits loaded into the IR shift register in Capture-IR.
    localparam logic [1:0] C_IR_CAPTURE = 2'b01;

endpackage
`default_nettype wire

// File: rtl/pm_tap_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : pm_tap_fsm
//  Description : 16-state 1149.1 TAP state machine. Next-state logic and
//                state register only.
//  Ports       : clk       - test clock (TCK)
//                rst_n     - asynchronous active-low reset (TRST_N)
//                tms       - test mode select, sampled on rising clk
//                tap_state - current state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
module pm_tap_fsm
    import pm_tap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tms,
    output logic [3:0] tap_state
);

    tap_state_e r_state;
    tap_state_e w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_TLR:        w_next = tms ? ST_TLR       : ST_RTI;
            ST_RTI:        w_next = tms ? ST_SELECT_DR : ST_RTI;
            ST_SELECT_DR:  w_next = tms ? ST_SELECT_IR : ST_CAPTURE_DR;
            ST_CAPTURE_DR: w_next = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_SHIFT_DR:   w_next = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_EXIT1_DR:   w_next = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:   w_next = tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
            ST_EXIT2_DR:   w_next = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR:  w_next = tms ? ST_SELECT_DR : ST_RTI;
            ST_SELECT_IR:  w_next = tms ? ST_TLR       : ST_CAPTURE_IR;
            ST_CAPTURE_IR: w_next = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_SHIFT_IR:   w_next = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_EXIT1_IR:   w_next = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:   w_next = tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
            ST_EXIT2_IR:   w_next = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR:  w_next = tms ? ST_SELECT_DR : ST_RTI;
            default:       w_next = ST_TLR;
        endcase
    end

    assign tap_state = r_state;

endmodule
`default_nettype wire

// File: rtl/pm_tap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pm_tap_ctrl
//  Description : 1149.1-style TAP controller for the PM control island.
//                Owns the IR, bypass bit and IDCODE register, produces
//                per-DR capture/shift/update strobes and muxes tdo.
//  Ports       : clk, rst_n          - TCK and asynchronous TRST_N
//                tms, tdi            - TAP inputs
//                tdo, tdo_en         - TAP output and its enable
//                dr_serial_out       - serial outputs of the user DRs
//                dr_capture/shift/update - per-DR strobes (gated by select)
//                dr_select           - one-hot user DR select
//                ir_out              - current instruction
//                tap_state           - current FSM state (debug)
//                test_logic_reset    - high in Test-Logic-Reset
//  Revision    : 1.0 - initial release
// ============================================================================
module pm_tap_ctrl
    import pm_tap_pkg::*;
#(
    parameter int          IR_LENGTH    = 4,
    parameter int          N_DR         = 4,
    parameter int          DR_BASE      = 2,
    parameter int          IDCODE_INSTR = 1,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tms,
    input  logic                 tdi,
    output logic                 tdo,
    output logic                 tdo_en,
    input  logic [N_DR-1:0]      dr_serial_out,
    output logic [N_DR-1:0]      dr_capture,
    output logic [N_DR-1:0]      dr_shift,
    output logic [N_DR-1:0]      dr_update,
    output logic [N_DR-1:0]      dr_select,
    output logic [IR_LENGTH-1:0] ir_out,
    output logic [3:0]           tap_state,
    output logic                 test_logic_reset
);

    localparam logic [IR_LENGTH-1:0] C_IDCODE_IR   = IR_LENGTH'(IDCODE_INSTR);
    localparam logic [IR_LENGTH-1:0] C_IR_CAP_WORD = IR_LENGTH'(C_IR_CAPTURE);

    logic                 w_tlr;
    logic                 w_capture_dr;
    logic                 w_shift_dr;
    logic                 w_update_dr;
    logic                 w_capture_ir;
    logic                 w_shift_ir;
    logic                 w_update_ir;
    logic                 w_sel_idcode;
    logic                 w_sel_bypass;

    logic [IR_LENGTH-1:0] r_ir_sr;
    logic [IR_LENGTH-1:0] r_ir;
    logic [31:0]          r_idcode_sr;
    logic                 r_bypass;

    pm_tap_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .tms       (tms),
        .tap_state (tap_state)
    );

    assign w_tlr        = (tap_state == ST_TLR);
    assign w_capture_dr = (tap_state == ST_CAPTURE_DR);
    assign w_shift_dr   = (tap_state == ST_SHIFT_DR);
    assign w_update_dr  = (tap_state == ST_UPDATE_DR);
    assign w_capture_ir = (tap_state == ST_CAPTURE_IR);
    assign w_shift_ir   = (tap_state == ST_SHIFT_IR);
    assign w_update_ir  = (tap_state == ST_UPDATE_IR);

    // Instruction shift register and the updated instruction. r_ir is also
    // reloaded while sitting in TLR so the IDCODE default survives leaving it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_sr <= '0;
            r_ir    <= C_IDCODE_IR;
        end else begin
            if (w_capture_ir) begin
                r_ir_sr <= C_IR_CAP_WORD;
            end else if (w_shift_ir) begin
                r_ir_sr <= {tdi, r_ir_sr[IR_LENGTH-1:1]};
            end

            if (w_update_ir) begin
                r_ir <= r_ir_sr;
            end else if (w_tlr) begin
                r_ir <= C_IDCODE_IR;
            end
        end
    end

    // Entering TLR must switch the instruction on that same edge, so the
    // override is applied from the state register rather than waiting a cycle.
    assign ir_out = w_tlr ? C_IDCODE_IR : r_ir;

    generate
        for (genvar gi = 0; gi < N_DR; gi++) begin : g_dr
            assign dr_select[gi]  = (ir_out == IR_LENGTH'(DR_BASE + gi));
            assign dr_capture[gi] = w_capture_dr & dr_select[gi];
            assign dr_shift[gi]   = w_shift_dr   & dr_select[gi];
            assign dr_update[gi]  = w_update_dr  & dr_select[gi];
        end
    endgenerate

    assign w_sel_idcode = (ir_out == C_IDCODE_IR) & ~(|dr_select);
    assign w_sel_bypass = ~w_sel_idcode & ~(|dr_select);

    // Internal data registers only act while they are the selected DR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idcode_sr <= IDCODE_VALUE;
            r_bypass    <= 1'b0;
        end else if (w_capture_dr) begin
            if (w_sel_idcode) begin
                r_idcode_sr <= IDCODE_VALUE;
            end
            if (w_sel_bypass) begin
                r_bypass <= 1'b0;
            end
        end else if (w_shift_dr) begin
            if (w_sel_idcode) begin
                r_idcode_sr <= {tdi, r_idcode_sr[31:1]};
            end
            if (w_sel_bypass) begin
                r_bypass <= tdi;
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (w_shift_ir) begin
            tdo = r_ir_sr[0];
        end else if (w_shift_dr) begin
            if (|dr_select) begin
                tdo = |(dr_select & dr_serial_out);
            end else if (w_sel_idcode) begin
                tdo = r_idcode_sr[0];
            end else begin
                tdo = r_bypass;
            end
        end
    end

    assign tdo_en           = w_shift_ir | w_shift_dr;
    assign test_logic_reset = w_tlr;

endmodule
`default_nettype wire

// File: tb/tb_pm_tap_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pm_tap_ctrl
//  Description : Self-checking bench for pm_tap_ctrl. A queue-based
//                behavioural model predicts every output each cycle; directed
//                scenarios add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pm_tap_ctrl;

    localparam int          IRL = 4;
    localparam int          NDR = 4;
    localparam int          DRB = 2;
    localparam int          IDI = 1;
    localparam logic [31:0] IDV = 32'h5A3C_96E1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tms;
    logic           tdi;
    logic           tdo;
    logic           tdo_en;
    logic [NDR-1:0] dr_serial_out;
    logic [NDR-1:0] dr_capture;
    logic [NDR-1:0] dr_shift;
    logic [NDR-1:0] dr_update;
    logic [NDR-1:0] dr_select;
    logic [IRL-1:0] ir_out;
    logic [3:0]     tap_state;
    logic           test_logic_reset;

    always #5 clk = ~clk;

    pm_tap_ctrl #(
        .IR_LENGTH    (IRL),
        .N_DR         (NDR),
        .DR_BASE      (DRB),
        .IDCODE_INSTR (IDI),
        .IDCODE_VALUE (IDV)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tms              (tms),
        .tdi              (tdi),
        .tdo              (tdo),
        .tdo_en           (tdo_en),
        .dr_serial_out    (dr_serial_out),
        .dr_capture       (dr_capture),
        .dr_shift         (dr_shift),
        .dr_update        (dr_update),
        .dr_select        (dr_select),
        .ir_out           (ir_out),
        .tap_state        (tap_state),
        .test_logic_reset (test_logic_reset)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int cnt_cap [NDR];
    int cnt_shf [NDR];
    int cnt_upd [NDR];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: TAP graph as a lookup table, registers as bit
    // queues (front = bit presented on tdo).
    // ------------------------------------------------------------------
    int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nxt1 [16] = '{5, 5, 1, 0, 15,  7, 1, 4, 13, 13,  9,  8,  7,  7,  9, 15};

    localparam int S_SHDR = 2, S_UDR = 5, S_CDR = 6, S_SHIR = 10,
                   S_UIR = 13, S_CIR = 14, S_TLR = 15;

    int m_state;
    int m_ir;
    bit irq [$];
    bit idq [$];
    bit m_byp;

    function automatic bit is_user();
        return (m_ir >= DRB) && (m_ir < DRB + NDR);
    endfunction

    task automatic model_reset();
        m_state = S_TLR;
        m_ir    = IDI;
        irq.delete();
        repeat (IRL) irq.push_back(1'b0);
        idq.delete();
        for (int i = 0; i < 32; i++) idq.push_back(IDV[i]);
        m_byp = 1'b0;
    endtask

    task automatic model_step(input bit t_ms, input bit t_di);
        bit user;
        bit idc;
        user = is_user();
        idc  = (m_ir == IDI);
        case (m_state)
            S_CIR: begin
                irq.delete();
                irq.push_back(1'b1);
                repeat (IRL - 1) irq.push_back(1'b0);
            end
            S_SHIR: begin
                void'(irq.pop_front());
                irq.push_back(t_di);
            end
            S_UIR: begin
                m_ir = 0;
                for (int i = 0; i < IRL; i++) if (irq[i]) m_ir += (1 << i);
            end
            S_CDR: begin
                if (idc) begin
                    idq.delete();
                    for (int i = 0; i < 32; i++) idq.push_back(IDV[i]);
                end else if (!user) begin
                    m_byp = 1'b0;
                end
            end
            S_SHDR: begin
                if (idc) begin
                    void'(idq.pop_front());
                    idq.push_back(t_di);
                end else if (!user) begin
                    m_byp = t_di;
                end
            end
            default: ;
        endcase
        m_state = t_ms ? nxt1[m_state] : nxt0[m_state];
        if (m_state == S_TLR) m_ir = IDI;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step(tms, tdi);
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every output against the model, every cycle.
    // ------------------------------------------------------------------
    logic [NDR-1:0] e_sel;
    logic           e_tdo;

    always @(negedge clk) begin
        if (chk_en) begin
            e_sel = '0;
            if (is_user()) e_sel[m_ir - DRB] = 1'b1;
            e_tdo = 1'b0;
            if (m_state == S_SHIR) begin
                e_tdo = irq[0];
            end else if (m_state == S_SHDR) begin
                if (is_user())        e_tdo = dr_serial_out[m_ir - DRB];
                else if (m_ir == IDI) e_tdo = idq[0];
                else                  e_tdo = m_byp;
            end
            chk("tap_state", tap_state, m_state);
            chk("test_logic_reset", test_logic_reset, m_state == S_TLR);
            chk("ir_out", ir_out, m_ir);
            chk("dr_select", dr_select, e_sel);
            chk("dr_capture", dr_capture, (m_state == S_CDR) ? e_sel : '0);
            chk("dr_shift", dr_shift, (m_state == S_SHDR) ? e_sel : '0);
            chk("dr_update", dr_update, (m_state == S_UDR) ? e_sel : '0);
            chk("tdo_en", tdo_en, (m_state == S_SHDR) || (m_state == S_SHIR));
            chk("tdo", tdo, e_tdo);
            for (int i = 0; i < NDR; i++) begin
                cnt_cap[i] += int'(dr_capture[i]);
                cnt_shf[i] += int'(dr_shift[i]);
                cnt_upd[i] += int'(dr_update[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all run with inputs changing 2 ns after posedge)
    // ------------------------------------------------------------------
    task automatic tick(input bit t_ms, input bit t_di);
        tms           = t_ms;
        tdi           = t_di;
        dr_serial_out = NDR'($urandom);
        @(posedge clk);
        #2;
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < NDR; i++) begin
            cnt_cap[i] = 0;
            cnt_shf[i] = 0;
            cnt_upd[i] = 0;
        end
    endtask

    function automatic int sum_cnt(input int a [NDR], input int skip);
        int s = 0;
        for (int i = 0; i < NDR; i++) if (i != skip) s += a[i];
        return s;
    endfunction

    // Starts and ends in Run-Test/Idle.
    task automatic shift_ir(input logic [IRL-1:0] v, output logic [IRL-1:0] tb);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < IRL; i++) begin
            tb[i] = tdo;
            tick(i == IRL - 1, v[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // Starts and ends in Run-Test/Idle; n cycles spent in Shift-DR.
    task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            tick(i == n - 1, din[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    logic [IRL-1:0] ir_tdo;
    logic [63:0]    dout;

    initial begin
        rst_n         = 1'b0;
        tms           = 1'b1;
        tdi           = 1'b0;
        dr_serial_out = '0;
        clr_cnt();
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;

        // Reset values
        chk("rst tap_state", tap_state, 4'hF);
        chk("rst ir_out", ir_out, 4'd1);
        chk("rst strobes", {dr_capture, dr_shift, dr_update}, '0);
        chk("rst tdo_en", tdo_en, 1'b0);
        chk("rst tdo", tdo, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);

        // IDCODE read straight after reset
        clr_cnt();
        shift_dr(32, {32'h0, $urandom}, dout);
        chk("idcode tdo", dout[31:0], 32'h5A3C_96E1);
        chk("idcode no dr_shift", sum_cnt(cnt_shf, -1), 0);

        // Five tms=1 cycles from Shift-DR reach TLR
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("in shift_dr", tap_state, 4'h2);
        repeat (5) tick(1'b1, 1'b0);
        chk("tms5 tlr", tap_state, 4'hF);
        tick(1'b0, 1'b0);

        // IR load: tdi 0,1,0,0 LSB first -> instruction 2
        shift_ir(4'b0010, ir_tdo);
        chk("ir capture tdo", ir_tdo[1:0], 2'b01);
        chk("ir load ir_out", ir_out, 4'd2);
        chk("ir load dr_select", dr_select, 4'b0001);

        // Bypass: tdi sequence 1,0,1,1,0,0,1,1 -> tdo delayed by one, leading 0
        shift_ir(4'hF, ir_tdo);
        chk("bypass ir_out", ir_out, 4'hF);
        shift_dr(8, 64'hCD, dout);
        chk("bypass tdo", dout[7:0], 8'h9A);

        // User DR 1: 1 capture, 16 shifts, 1 update, nothing elsewhere
        shift_ir(4'd3, ir_tdo);
        chk("dr1 select", dr_select, 4'b0010);
        clr_cnt();
        shift_dr(16, {32'h0, $urandom}, dout);
        chk("dr1 capture count", cnt_cap[1], 1);
        chk("dr1 shift count", cnt_shf[1], 16);
        chk("dr1 update count", cnt_upd[1], 1);
        chk("dr1 other strobes",
            sum_cnt(cnt_cap, 1) + sum_cnt(cnt_shf, 1) + sum_cnt(cnt_upd, 1), 0);

        // Reset during Shift-DR cycle 5 of a DR 0 shift
        shift_ir(4'd2, ir_tdo);
        clr_cnt();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'($urandom_range(0, 1)));
        #4;
        rst_n = 1'b0;
        chk("midrst shift count", cnt_shf[0], 5);
        @(posedge clk);
        #2;
        chk("midrst tap_state", tap_state, 4'hF);
        chk("midrst ir_out", ir_out, 4'd1);
        chk("midrst tdo_en", tdo_en, 1'b0);
        rst_n = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("midrst no update", cnt_upd[0], 0);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                tick(1'b0, 1'b0);
                rst_n = 1'b1;
            end else begin
                tick($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
